// File: rtl/mpy_32_16_sched.sv
// Round-robin front end for one shared, fully pipelined Mpy_32_16 multiplier.
// Grants at most one requester per cycle and routes each product back by ID after a fixed latency.
module mpy_32_16_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MPY_LAT = 9,
    localparam int CW     = $clog2(MPY_LAT + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_hi,
    input  logic [NREQ*16-1:0]   req_lo,
    input  logic [NREQ*16-1:0]   req_n,
    input  logic                 drain,
    output logic [15:0]          mpy_hi,
    output logic [15:0]          mpy_lo,
    output logic [15:0]          mpy_n,
    input  logic [31:0]          mpy_outf,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic [CW-1:0]        inflight,
    output logic                 idle
);

    logic [IDW-1:0]  rr_reg;
    logic [IDW-1:0]  grant_id;
    logic            grant_found;
    logic            handshake;
    logic [15:0]     hi_arr [NREQ];
    logic [15:0]     lo_arr [NREQ];
    logic [15:0]     n_arr  [NREQ];
    logic [15:0]     mpy_hi_reg, mpy_lo_reg, mpy_n_reg;
    logic            tag_valid_reg [MPY_LAT+1];
    logic [IDW-1:0]  tag_id_reg    [MPY_LAT+1];
    logic [NREQ-1:0] rsp_valid_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [31:0]     rsp_data_reg;
    logic [CW-1:0]   inflight_reg;
    logic [CW-1:0]   inflight_next;
    logic            rsp_capture;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign hi_arr[gi]    = req_hi[16*gi +: 16];
            assign lo_arr[gi]    = req_lo[16*gi +: 16];
            assign n_arr[gi]     = req_n[16*gi +: 16];
            assign req_ready[gi] = handshake && (grant_id == IDW'(gi));
        end
    endgenerate

    // First valid requester at or after the rr pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign handshake = grant_found && !drain && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_reg     <= '0;
            mpy_hi_reg <= '0;
            mpy_lo_reg <= '0;
            mpy_n_reg  <= '0;
        end else if (handshake) begin
            rr_reg     <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            mpy_hi_reg <= hi_arr[grant_id];
            mpy_lo_reg <= lo_arr[grant_id];
            mpy_n_reg  <= n_arr[grant_id];
        end
    end

    // Tag pipe runs in lockstep with the multiplier so the product and its owner arrive together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= '0;
        end else begin
            tag_valid_reg[0] <= handshake;
            tag_id_reg[0]    <= grant_id;
        end
    end

    generate
        for (gi = 1; gi <= MPY_LAT; gi++) begin : g_tag
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rsp_capture = tag_valid_reg[MPY_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_reg <= '0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
        end else if (rsp_capture) begin
            rsp_valid_reg <= NREQ'(1) << tag_id_reg[MPY_LAT];
            rsp_id_reg    <= tag_id_reg[MPY_LAT];
            rsp_data_reg  <= mpy_outf;
        end else begin
            rsp_valid_reg <= '0;
        end
    end

    always_comb begin
        inflight_next = inflight_reg;
        case ({handshake, rsp_capture})
            2'b10:   inflight_next = inflight_reg + CW'(1);
            2'b01:   inflight_next = inflight_reg - CW'(1);
            default: inflight_next = inflight_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) inflight_reg <= '0;
        else        inflight_reg <= inflight_next;
    end

    assign mpy_hi    = mpy_hi_reg;
    assign mpy_lo    = mpy_lo_reg;
    assign mpy_n     = mpy_n_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign inflight  = inflight_reg;
    assign idle      = (inflight_reg == '0) && !handshake;

endmodule

// File: tb/tb_mpy_32_16_sched.sv
// Scoreboard bench for mpy_32_16_sched with a behavioural pipelined Mpy_32_16 attached.
module tb_mpy_32_16_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 9;
    localparam int CW   = $clog2(LAT + 2);

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_hi, req_lo, req_n;
    logic              drain;
    logic [15:0]       mpy_hi, mpy_lo, mpy_n;
    logic [31:0]       mpy_outf;
    logic [NREQ-1:0]   rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_data;
    logic [CW-1:0]     inflight;
    logic              idle;

    mpy_32_16_sched #(.NREQ(NREQ), .IDW(IDW), .MPY_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_hi(req_hi), .req_lo(req_lo), .req_n(req_n), .drain(drain),
        .mpy_hi(mpy_hi), .mpy_lo(mpy_lo), .mpy_n(mpy_n), .mpy_outf(mpy_outf),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ETSI-style Mpy_32_16 reference used only as the attached multiplier.
    function automatic logic [31:0] mpy_model(logic [15:0] hi, logic [15:0] lo, logic [15:0] n);
        longint p, m, s;
        p = longint'($signed(hi)) * longint'($signed(n)) * 2;
        if (p > 64'sh7FFFFFFF) p = 64'sh7FFFFFFF;
        m = (longint'($signed(lo)) * longint'($signed(n))) >>> 15;
        if (m > 32767) m = 32767;
        s = p + 2 * m;
        if (s > 64'sh7FFFFFFF) s = 64'sh7FFFFFFF;
        if (s < -64'sh80000000) s = -64'sh80000000;
        return 32'(s);
    endfunction

    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= mpy_model(mpy_hi, mpy_lo, mpy_n);
        for (int j = 1; j < LAT; j++) mpipe[j] <= mpipe[j-1];
    end
    assign mpy_outf = mpipe[LAT-1];

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL rsp_missing: id %0d due cycle %0d not seen by cycle %0d",
                     exp_q[0].id, exp_q[0].due, cyc);
            void'(exp_q.pop_front());
        end
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b id=%0d data=0x%08h, none expected (cycle %0d)",
                         rsp_valid, rsp_id, rsp_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (rsp_id !== IDW'(e.id) || rsp_data !== e.data || cyc != e.due ||
                    rsp_valid !== (NREQ'(1) << e.id)) begin
                    errors++;
                    $display("FAIL rsp: got valid=%b id=%0d data=0x%08h cycle=%0d, expected valid=%b id=%0d data=0x%08h cycle=%0d",
                             rsp_valid, rsp_id, rsp_data, cyc, NREQ'(1) << e.id, e.id, e.data, e.due);
                end else begin
                    $display("rsp  id=%0d data=0x%08h cycle=%0d", rsp_id, rsp_data, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(int i, logic [15:0] hi, logic [15:0] lo, logic [15:0] n);
        req_hi[16*i +: 16] = hi;
        req_lo[16*i +: 16] = lo;
        req_n[16*i +: 16]  = n;
    endtask

    // Handshake lands on the next edge; response is visible after edge +LAT+1 from that.
    task automatic expect_rsp(int id, logic [31:0] data);
        exp_t e;
        e.id = id; e.data = data; e.due = cyc + LAT + 2;
        exp_q.push_back(e);
    endtask

    logic [31:0] cont_d [4];
    logic [31:0] mix_d  [4];

    initial begin
        cont_d[0] = 32'h0000_8000; cont_d[1] = 32'h0080_0000;
        cont_d[2] = 32'h0800_0000; cont_d[3] = 32'h1000_0000;
        mix_d[0]  = 32'hE000_0000; mix_d[1]  = 32'h7FFF_FFFF;
        mix_d[2]  = 32'h2000_0000; mix_d[3]  = 32'h0000_4000;

        reset = 1'b0; drain = 1'b0; req_valid = '1;
        req_hi = '0; req_lo = '0; req_n = '0;
        tick(); tick(); tick();
        check("reset_ready", 64'(req_ready), 64'h0);
        check("reset_mpy", {16'h0, mpy_hi, mpy_lo, mpy_n}, 64'h0);
        check("reset_rsp", {28'h0, rsp_valid, rsp_data}, 64'h0);
        check("reset_inflight", 64'(inflight), 64'h0);
        req_valid = '0;
        reset = 1'b1;
        tick();
        check("idle_after_reset", 64'(idle), 64'h1);

        // Contention: four requesters, rr starts at 0
        set_ops(0, 16'h0001, 16'h0000, 16'h4000);
        set_ops(1, 16'h0100, 16'h0000, 16'h4000);
        set_ops(2, 16'h1000, 16'h0000, 16'h4000);
        set_ops(3, 16'h2000, 16'h0000, 16'h4000);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("cont_grant%0d", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
            expect_rsp(c % 4, cont_d[c % 4]);
            tick();
        end
        req_valid = '0;
        repeat (12) tick();

        // Single op on requester 2
        set_ops(2, 16'h4000, 16'h0000, 16'h4000);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 64'(req_ready), 64'h4);
        check("single_idle_hs", 64'(idle), 64'h0);
        expect_rsp(2, 32'h2000_0000);
        tick();
        req_valid = '0;
        #1;
        check("single_mpy", {16'h0, mpy_hi, mpy_lo, mpy_n}, 64'h0000_4000_0000_4000);
        check("single_inflight1", 64'(inflight), 64'h1);
        repeat (9) tick();
        check("single_inflight_before", 64'(inflight), 64'h1);
        tick();
        check("single_inflight0", 64'(inflight), 64'h0);
        check("single_idle", 64'(idle), 64'h1);

        // Saturation, lo path and negative operand; rr is 3 here
        set_ops(1, 16'h8000, 16'h0000, 16'h8000);
        set_ops(3, 16'h0000, 16'h4000, 16'h4000);
        set_ops(0, 16'hC000, 16'h0000, 16'h4000);
        req_valid = 4'b0010;
        #1; check("sat_ready", 64'(req_ready), 64'h2);
        expect_rsp(1, 32'h7FFF_FFFF); tick();
        req_valid = 4'b1000;
        #1; check("lo_ready", 64'(req_ready), 64'h8);
        expect_rsp(3, 32'h0000_4000); tick();
        req_valid = 4'b0001;
        #1; check("neg_ready", 64'(req_ready), 64'h1);
        expect_rsp(0, 32'hE000_0000); tick();
        req_valid = '0;
        repeat (12) tick();

        // Fill the pipe starting at rr=1, then drain
        req_valid = 4'b1111;
        for (int c = 0; c < 11; c++) begin
            #1;
            check($sformatf("fill_grant%0d", c), 64'(req_ready), 64'(4'b0001 << ((c + 1) % 4)));
            expect_rsp((c + 1) % 4, mix_d[(c + 1) % 4]);
            tick();
        end
        drain = 1'b1;
        #1;
        check("fill_inflight_max", 64'(inflight), 64'd10);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("drain_ready%0d", c), 64'(req_ready), 64'h0);
            if (c == 1) check("drain_inflight9", 64'(inflight), 64'd9);
            tick();
        end
        check("drain_inflight0", 64'(inflight), 64'h0);
        check("drain_idle", 64'(idle), 64'h1);
        drain = 1'b0;
        #1;
        check("drain_resume_rr", 64'(req_ready), 64'h1);
        expect_rsp(0, mix_d[0]);
        tick();

        // Reset in the middle of a burst
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("pre_rst_grant%0d", c), 64'(req_ready), 64'(4'b0001 << ((c + 1) % 4)));
            tick();
        end
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_outputs", {28'h0, rsp_valid, rsp_data}, 64'h0);
        check("midrst_mpy", {16'h0, mpy_hi, mpy_lo, mpy_n}, 64'h0);
        check("midrst_inflight_ready", {56'h0, 4'(inflight), req_ready}, 64'h0);
        tick(); tick();
        req_valid = '0;
        reset = 1'b1;
        repeat (15) tick();
        req_valid = 4'b1111;
        #1;
        check("postrst_rr0", 64'(req_ready), 64'h1);
        expect_rsp(0, mix_d[0]);
        tick();
        req_valid = '0;
        repeat (14) tick();
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
